hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage RV32 core (IF, ID, EX, MEM, WB).
- Keeps a shadow scoreboard of the destination registers in flight in EX, MEM and WB.
- Compares the instruction in ID against the scoreboard and drives four kinds of control: IF/ID stall, ID/EX bubble insertion, branch flush, and per-operand forwarding selects for EX.
- Sits beside the instruction decode stage; its outputs gate the PC, IF/ID and ID/EX pipeline registers.

---
 rtl/hazard_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage RV32 pipeline.
// Tracks the destinations in flight in EX/MEM/WB, stalls or bubbles the
// instruction in ID on RAW hazards, squashes it on a taken branch and
// registers the EX forwarding selects.
// Optional feature macro: HAZARD_FWD_EN (defined = forwarding present,
// only load-use stalls; undefined = no bypass, any RAW match stalls).
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_rd,
  input  logic             branch_taken,
  input  logic             hold,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  // Scoreboard entries: {valid, rd, reg_write}; only EX needs mem_rd,
  // because a load can only cause a hazard while it sits in EX.
  logic             ex_valid_q, ex_valid_d, ex_rw_q, ex_rw_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic             mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d;
  logic [REG_W-1:0] mem_rd_q, mem_rd_d;
  logic             wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d;
  logic [REG_W-1:0] wb_rd_q, wb_rd_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic ex_live_s, mem_live_s, wb_live_s;
  logic rs1_ex_s, rs1_mem_s, rs1_wb_s, rs2_ex_s, rs2_mem_s, rs2_wb_s;
  logic hazard_s, stall_s, bubble_s, flush_s;

`ifdef HAZARD_FWD_EN
  logic       ex_mrd_q, ex_mrd_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  // With forwarding the WB entry never stalls: the bypass covers it.
  logic       unused_wb_s;
  assign unused_wb_s = rs1_wb_s ^ rs2_wb_s;
`else
  // Without forwarding the load flag is irrelevant: every RAW match stalls.
  logic       unused_mem_rd_s;
  assign unused_mem_rd_s = id_mem_rd;
`endif

  // Source matching against live entries, hazard decision and pipe controls.
  always_comb begin
    ex_live_s  = ex_valid_q  && ex_rw_q  && (ex_rd_q  != {REG_W{1'b0}});
    mem_live_s = mem_valid_q && mem_rw_q && (mem_rd_q != {REG_W{1'b0}});
    wb_live_s  = wb_valid_q  && wb_rw_q  && (wb_rd_q  != {REG_W{1'b0}});
    rs1_ex_s   = id_valid && id_use_rs1 && ex_live_s  && (id_rs1 == ex_rd_q);
    rs1_mem_s  = id_valid && id_use_rs1 && mem_live_s && (id_rs1 == mem_rd_q);
    rs1_wb_s   = id_valid && id_use_rs1 && wb_live_s  && (id_rs1 == wb_rd_q);
    rs2_ex_s   = id_valid && id_use_rs2 && ex_live_s  && (id_rs2 == ex_rd_q);
    rs2_mem_s  = id_valid && id_use_rs2 && mem_live_s && (id_rs2 == mem_rd_q);
    rs2_wb_s   = id_valid && id_use_rs2 && wb_live_s  && (id_rs2 == wb_rd_q);
`ifdef HAZARD_FWD_EN
    hazard_s   = ex_mrd_q && (rs1_ex_s || rs2_ex_s);
`else
    hazard_s   = rs1_ex_s || rs1_mem_s || rs1_wb_s ||
                 rs2_ex_s || rs2_mem_s || rs2_wb_s;
`endif
    // A taken branch squashes the wrong-path ID instruction instead of stalling it.
    stall_s    = hold || (hazard_s && !branch_taken);
    bubble_s   = (hazard_s || branch_taken) && !hold;
    flush_s    = branch_taken && !hold;
  end

  // Scoreboard advance and forwarding-select computation for the next edge.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rd_d     = ex_rd_q;
    ex_rw_d     = ex_rw_q;
    mem_valid_d = mem_valid_q;
    mem_rd_d    = mem_rd_q;
    mem_rw_d    = mem_rw_q;
    wb_valid_d  = wb_valid_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = wb_rw_q;
`ifdef HAZARD_FWD_EN
    ex_mrd_d    = ex_mrd_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
`endif
    if (!hold) begin
      wb_valid_d  = mem_valid_q;
      wb_rd_d     = mem_rd_q;
      wb_rw_d     = mem_rw_q;
      mem_valid_d = ex_valid_q;
      mem_rd_d    = ex_rd_q;
      mem_rw_d    = ex_rw_q;
      if (id_valid && !bubble_s) begin
        ex_valid_d = 1'b1;
        ex_rd_d    = id_rd;
        ex_rw_d    = id_reg_write;
`ifdef HAZARD_FWD_EN
        ex_mrd_d   = id_mem_rd;
`endif
      end else begin
        ex_valid_d = 1'b0;
        ex_rd_d    = {REG_W{1'b0}};
        ex_rw_d    = 1'b0;
`ifdef HAZARD_FWD_EN
        ex_mrd_d   = 1'b0;
`endif
      end
`ifdef HAZARD_FWD_EN
      // EX producer moves to MEM (01); MEM producer moves to WB (10); EX wins.
      if (bubble_s) begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
      end else begin
        fwd_a_d = rs1_ex_s ? 2'b01 : (rs1_mem_s ? 2'b10 : 2'b00);
        fwd_b_d = rs2_ex_s ? 2'b01 : (rs2_mem_s ? 2'b10 : 2'b00);
      end
`endif
    end else begin
      wb_valid_d = wb_valid_q;
      ex_valid_d = ex_valid_q;
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    if (stall_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= {REG_W{1'b0}};
      ex_rw_q        <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= {REG_W{1'b0}};
      mem_rw_q       <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= {REG_W{1'b0}};
      wb_rw_q        <= 1'b0;
      stall_cycles_q <= {CNT_W{1'b0}};
`ifdef HAZARD_FWD_EN
      ex_mrd_q       <= 1'b0;
      fwd_a_q        <= 2'b00;
      fwd_b_q        <= 2'b00;
`endif
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_rw_q        <= ex_rw_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_rw_q       <= mem_rw_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_rw_q        <= wb_rw_d;
      stall_cycles_q <= stall_cycles_d;
`ifdef HAZARD_FWD_EN
      ex_mrd_q       <= ex_mrd_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
`endif
    end
  end

  assign stall_if_id  = stall_s;
  assign bubble_ex    = bubble_s;
  assign flush_if_id  = flush_s;
  assign stall_cycles = stall_cycles_q;
`ifdef HAZARD_FWD_EN
  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule
